// File: rtl/depthwise_layer_sequencer_pkg.sv
// Shared types and default geometry for the depthwise layer sequencer.
// Holds the FSM state encoding and the default frame/timeout constants.
package depthwise_layer_sequencer_pkg;

  localparam int DEFAULT_IMG_WIDHT     = 44;
  localparam int DEFAULT_IMG_HEIGHT    = 44;
  localparam int DEFAULT_ADDR_W        = 12;
  localparam int DEFAULT_DRAIN_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/depthwise_layer_sequencer_if.sv
// Control, source-read, datapath-valid and destination-write signals of the sequencer.
// The sequencer uses the slave view; whoever drives start/pause/conv_valid_out uses master.
interface depthwise_layer_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              pause;
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_rd_addr;
  logic              conv_valid_in;
  logic              conv_valid_out;
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_wr_addr;
  logic [ADDR_W-1:0] cur_row;
  logic [ADDR_W-1:0] cur_col;
  logic              busy;
  logic              done;
  logic              err_timeout;

  modport master (
    output start, pause, conv_valid_out,
    input  src_rd_en, src_rd_addr, conv_valid_in, dst_wr_en, dst_wr_addr,
    input  cur_row, cur_col, busy, done, err_timeout
  );

  modport slave (
    input  start, pause, conv_valid_out,
    output src_rd_en, src_rd_addr, conv_valid_in, dst_wr_en, dst_wr_addr,
    output cur_row, cur_col, busy, done, err_timeout
  );
endinterface

// File: rtl/depthwise_layer_sequencer_raster_pos_counter.sv
// Raster row/column tracker: row_o/col_o report the pixel of the most recent read,
// while an internal pointer holds the position the next read will fetch.
module raster_pos_counter #(
  parameter int WIDTH  = 44,
  parameter int HEIGHT = 44,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] row_o,
  output logic [ADDR_W-1:0] col_o
);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(HEIGHT - 1);

  logic [ADDR_W-1:0] nxt_row_q, nxt_row_d, nxt_col_q, nxt_col_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;

  always_comb begin
    nxt_row_d = nxt_row_q;
    nxt_col_d = nxt_col_q;
    row_d     = row_q;
    col_d     = col_q;
    if (clr_i) begin
      nxt_row_d = '0;
      nxt_col_d = '0;
      row_d     = '0;
      col_d     = '0;
    end else if (en_i) begin
      row_d = nxt_row_q;
      col_d = nxt_col_q;
      if (nxt_col_q == COL_LAST) begin
        nxt_col_d = '0;
        nxt_row_d = (nxt_row_q == ROW_LAST) ? '0 : nxt_row_q + 1'b1;
      end else begin
        nxt_col_d = nxt_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nxt_row_q <= '0;
      nxt_col_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      nxt_row_q <= nxt_row_d;
      nxt_col_q <= nxt_col_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;
endmodule

// File: rtl/depthwise_layer_sequencer.sv
// Frame sequencer for the 16-channel depthwise datapath: streams a frame out of the
// source buffer in raster order and counts datapath results into the destination buffer.
module depthwise_layer_sequencer
  import depthwise_layer_sequencer_pkg::*;
#(
  parameter int IMG_WIDHT     = DEFAULT_IMG_WIDHT,
  parameter int IMG_HEIGHT    = DEFAULT_IMG_HEIGHT,
  parameter int ADDR_W        = DEFAULT_ADDR_W,
  parameter int DRAIN_TIMEOUT = DEFAULT_DRAIN_TIMEOUT
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  depthwise_layer_sequencer_if.slave bus_io
);
  localparam int                N        = IMG_WIDHT * IMG_HEIGHT;
  localparam int                TO_W     = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              cvi_q, err_q, err_d;
  logic              clr, in_run, rd_en, wr_en, last_rd, last_wr;

  assign in_run  = (state_q == FEED) || (state_q == DRAIN);
  assign rd_en   = (state_q == FEED) && !bus_io.pause;
  assign wr_en   = in_run && bus_io.conv_valid_out;
  assign last_rd = rd_en && (rd_cnt_q == LAST_IDX);
  assign last_wr = wr_en && (wr_cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (bus_io.start) begin
        state_d = FEED;
        clr     = 1'b1;
      end
      // Zero-latency datapaths can retire the last result alongside the last read.
      FEED: if (last_rd) state_d = last_wr ? DONE : DRAIN;
      DRAIN: begin
        if (last_wr) begin
          state_d = DONE;
        end else if (!bus_io.conv_valid_out && (to_cnt_q == TO_LAST)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      ERR: if (bus_io.start) begin
        state_d = FEED;
        clr     = 1'b1;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // The timeout counter idles at zero outside DRAIN, so entering DRAIN starts it cleared.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    to_cnt_d = '0;
    if (clr) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
      if (wr_en) wr_cnt_d = wr_cnt_q + 1'b1;
      if ((state_q == DRAIN) && !bus_io.conv_valid_out) to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      to_cnt_q <= '0;
      cvi_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      to_cnt_q <= to_cnt_d;
      cvi_q    <= rd_en;
      err_q    <= err_d;
    end
  end

  raster_pos_counter #(
    .WIDTH  (IMG_WIDHT),
    .HEIGHT (IMG_HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_pos (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (rd_en),
    .clr_i  (clr),
    .row_o  (bus_io.cur_row),
    .col_o  (bus_io.cur_col)
  );

  assign bus_io.src_rd_en     = rd_en;
  assign bus_io.src_rd_addr   = rd_cnt_q;
  assign bus_io.conv_valid_in = cvi_q;
  assign bus_io.dst_wr_en     = wr_en;
  assign bus_io.dst_wr_addr   = wr_cnt_q;
  assign bus_io.busy          = in_run;
  assign bus_io.done          = (state_q == DONE);
  assign bus_io.err_timeout   = err_q;
endmodule

// File: tb/tb_depthwise_layer_sequencer.sv
// Directed bench: 44x44 sequencer with a 50-cycle model datapath, plus a 3x3 instance
// with its datapath valid looped straight back from the read strobe.
`timescale 1ns/1ps
module tb_depthwise_layer_sequencer;
  localparam int W = 44, H = 44, N = W * H, AW = 12, TO = 16, LAT = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  depthwise_layer_sequencer_if #(.ADDR_W(AW)) bus ();
  depthwise_layer_sequencer_if #(.ADDR_W(4))  bus3 ();

  depthwise_layer_sequencer #(
    .IMG_WIDHT(W), .IMG_HEIGHT(H), .ADDR_W(AW), .DRAIN_TIMEOUT(TO)
  ) dut (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus));

  depthwise_layer_sequencer #(
    .IMG_WIDHT(3), .IMG_HEIGHT(3), .ADDR_W(4), .DRAIN_TIMEOUT(16)
  ) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus3));

  // Model datapath: fixed latency, optional withholding of the last 5 results, injection.
  logic [LAT-1:0] pipe;
  int   emitted;
  logic withhold = 1'b0;
  logic inj_out  = 1'b0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[LAT-2:0], bus.conv_valid_in};

  always @(posedge clk or negedge rst_n)
    if (!rst_n)                   emitted <= 0;
    else if (bus.start)           emitted <= 0;
    else if (bus.conv_valid_out)  emitted <= emitted + 1;

  assign bus.conv_valid_out  = inj_out || (pipe[LAT-1] && !(withhold && emitted >= N - 5));
  assign bus3.conv_valid_out = bus3.src_rd_en;

  int n_checks = 0;
  int n_fail   = 0;

  int m_rd, m_wr, m_rd_bad, m_wr_bad, m_rd_paused, m_cvi_bad;
  int m_first_rd, m_last_rd, m_last_wr, m_last_out, m_end_cyc;
  bit m_done, m_err;

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  // Per-cycle monitor: drives pause/start shortly after negedge, samples 1ns later.
  task automatic run_frame(input int max_cyc, input bit toggle, input int restart_at);
    logic prev_rd;
    bit   restarted;
    prev_rd = 1'b0; restarted = 1'b0;
    m_rd = 0; m_wr = 0; m_rd_bad = 0; m_wr_bad = 0; m_rd_paused = 0; m_cvi_bad = 0;
    m_first_rd = -1; m_last_rd = -1; m_last_wr = -1; m_last_out = -1; m_end_cyc = -1;
    m_done = 0; m_err = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      bus.start = 1'b0;
      if (restart_at >= 0 && !restarted && m_rd >= restart_at) begin
        bus.start = 1'b1; restarted = 1'b1;
      end
      bus.pause = toggle ? (((cyc / 3) % 2) == 1) : 1'b0;
      #1;
      if (bus.conv_valid_in !== prev_rd) m_cvi_bad++;
      prev_rd = bus.src_rd_en;
      if (bus.src_rd_en) begin
        if (bus.src_rd_addr !== AW'(m_rd)) m_rd_bad++;
        if (bus.pause) m_rd_paused++;
        if (m_rd == 0) m_first_rd = cyc;
        m_last_rd = cyc;
        m_rd++;
      end
      if (bus.dst_wr_en) begin
        if (bus.dst_wr_addr !== AW'(m_wr)) m_wr_bad++;
        m_wr++; m_last_wr = cyc;
      end
      if (bus.conv_valid_out) m_last_out = cyc;
      if (bus.done) begin m_done = 1; m_end_cyc = cyc; break; end
      if (bus.err_timeout) begin m_err = 1; m_end_cyc = cyc; break; end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.src_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_src_rd_en: got %b want 0", bus.src_rd_en); end
    n_checks++; if (bus.conv_valid_in !== 1'b0) begin n_fail++; $display("FAIL reset_cvi: got %b want 0", bus.conv_valid_in); end
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", bus.busy, bus.done); end
    n_checks++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_timeout); end
    n_checks++; if (bus.src_rd_addr !== 12'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", bus.src_rd_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_idle_ignore();
    int bad;
    bad = 0;
    @(negedge clk); inj_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.dst_wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      @(negedge clk);
    end
    inj_out = 1'b0;
    #1;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_valid_out: got %0d bad cycles want 0", bad); end
    n_checks++; if (bus.dst_wr_addr !== 12'd0) begin n_fail++; $display("FAIL idle_wr_addr: got %0d want 0", bus.dst_wr_addr); end
    $display("idle: conv_valid_out injected for 3 cycles, bad=%0d", bad);
  endtask

  task automatic test_basic();
    pulse_start();
    run_frame(5000, 1'b0, -1);
    $display("basic frame: reads=%0d writes=%0d done=%0d", m_rd, m_wr, m_done);
    n_checks++; if (m_first_rd != 0) begin n_fail++; $display("FAIL basic_start_latency: got %0d want 0", m_first_rd); end
    n_checks++; if (m_rd != N || m_rd_bad != 0) begin n_fail++; $display("FAIL basic_reads: got %0d (bad %0d) want %0d", m_rd, m_rd_bad, N); end
    n_checks++; if (m_wr != N || m_wr_bad != 0) begin n_fail++; $display("FAIL basic_writes: got %0d (bad %0d) want %0d", m_wr, m_wr_bad, N); end
    n_checks++; if (!m_done || m_end_cyc - m_last_wr != 1) begin n_fail++; $display("FAIL basic_done_timing: got done=%0d gap=%0d want 1/1", m_done, m_end_cyc - m_last_wr); end
    n_checks++; if (m_cvi_bad != 0) begin n_fail++; $display("FAIL basic_cvi_align: got %0d bad want 0", m_cvi_bad); end
    // start during DONE must be dropped
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
  endtask

  task automatic test_busy_start();
    pulse_start();
    run_frame(5000, 1'b0, 100);
    $display("busy restart frame: reads=%0d writes=%0d done=%0d", m_rd, m_wr, m_done);
    n_checks++; if (m_rd != N || m_rd_bad != 0) begin n_fail++; $display("FAIL busy_start_reads: got %0d (bad %0d) want %0d", m_rd, m_rd_bad, N); end
    n_checks++; if (!m_done || m_wr != N || m_wr_bad != 0) begin n_fail++; $display("FAIL busy_start_writes: got %0d done=%0d want %0d", m_wr, m_done, N); end
  endtask

  task automatic test_pause();
    pulse_start();
    run_frame(10000, 1'b1, -1);
    $display("paused frame: reads=%0d writes=%0d last_read_cycle=%0d", m_rd, m_wr, m_last_rd);
    n_checks++; if (m_rd_paused != 0) begin n_fail++; $display("FAIL pause_read_while_paused: got %0d want 0", m_rd_paused); end
    n_checks++; if (m_rd != N || m_rd_bad != 0) begin n_fail++; $display("FAIL pause_reads: got %0d (bad %0d) want %0d", m_rd, m_rd_bad, N); end
    n_checks++; if (m_last_rd != 3870) begin n_fail++; $display("FAIL pause_last_read_cycle: got %0d want 3870", m_last_rd); end
    n_checks++; if (m_cvi_bad != 0) begin n_fail++; $display("FAIL pause_cvi_align: got %0d bad want 0", m_cvi_bad); end
    n_checks++; if (!m_done || m_wr != N) begin n_fail++; $display("FAIL pause_writes: got %0d done=%0d want %0d", m_wr, m_done, N); end
  endtask

  task automatic test_timeout();
    withhold = 1'b1;
    pulse_start();
    run_frame(5000, 1'b0, -1);
    $display("timeout frame: writes=%0d err=%0d idle_gap=%0d", m_wr, m_err, m_end_cyc - m_last_out);
    n_checks++; if (!m_err || m_done) begin n_fail++; $display("FAIL timeout_err: got err=%0d done=%0d want 1/0", m_err, m_done); end
    n_checks++; if (m_wr != N - 5) begin n_fail++; $display("FAIL timeout_writes: got %0d want %0d", m_wr, N - 5); end
    n_checks++; if (m_end_cyc - m_last_out != 17) begin n_fail++; $display("FAIL timeout_gap: got %0d want 17", m_end_cyc - m_last_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", bus.busy); end
    withhold = 1'b0;
    pulse_start();
    run_frame(5000, 1'b0, -1);
    $display("rerun after timeout: reads=%0d writes=%0d done=%0d", m_rd, m_wr, m_done);
    n_checks++; if (!m_done || m_err) begin n_fail++; $display("FAIL rerun_done: got done=%0d err=%0d want 1/0", m_done, m_err); end
    n_checks++; if (m_rd != N || m_rd_bad != 0 || m_wr != N || m_wr_bad != 0) begin n_fail++; $display("FAIL rerun_counts: got rd=%0d wr=%0d want %0d", m_rd, m_wr, N); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int bad;
    found = 0; bad = 0;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (bus.src_rd_en && bus.src_rd_addr == 12'd700) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL reset_mid_reach_700: got 0 want 1"); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.src_rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.conv_valid_in !== 1'b0 || bus.dst_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got rd=%b busy=%b cvi=%b wr=%b want 0", bus.src_rd_en, bus.busy, bus.conv_valid_in, bus.dst_wr_en); end
    n_checks++; if (bus.src_rd_addr !== 12'd0 || bus.cur_row !== 12'd0 || bus.cur_col !== 12'd0) begin
      n_fail++; $display("FAIL reset_mid_counters: got addr=%0d row=%0d col=%0d want 0", bus.src_rd_addr, bus.cur_row, bus.cur_col); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (bus.conv_valid_in || bus.dst_wr_en || bus.busy) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d bad cycles want 0", bad); end
    pulse_start();
    run_frame(5000, 1'b0, -1);
    $display("frame after mid reset: reads=%0d writes=%0d done=%0d", m_rd, m_wr, m_done);
    n_checks++; if (m_first_rd != 0 || m_rd != N || m_rd_bad != 0) begin n_fail++; $display("FAIL reset_mid_rerun_reads: got first=%0d rd=%0d bad=%0d want 0/%0d/0", m_first_rd, m_rd, m_rd_bad, N); end
    n_checks++; if (!m_done || m_wr != N) begin n_fail++; $display("FAIL reset_mid_rerun_writes: got %0d want %0d", m_wr, N); end
  endtask

  task automatic test_small_frame();
    int bad;
    bad = 0;
    @(negedge clk); bus3.start = 1'b1;
    @(negedge clk); bus3.start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      #1;
      if (bus3.src_rd_en !== 1'b1 || bus3.src_rd_addr !== 4'(k) || bus3.busy !== 1'b1) bad++;
      if (k > 0 && (bus3.cur_row !== 4'((k - 1) / 3) || bus3.cur_col !== 4'((k - 1) % 3))) bad++;
      if (k == 8) begin
        n_checks++; if (bus3.dst_wr_en !== 1'b1 || bus3.dst_wr_addr !== 4'd8) begin n_fail++; $display("FAIL small_last_write: got en=%b addr=%0d want 1/8", bus3.dst_wr_en, bus3.dst_wr_addr); end
      end
      @(negedge clk);
    end
    #1;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL small_sequence: got %0d bad cycles want 0", bad); end
    n_checks++; if (bus3.done !== 1'b1 || bus3.busy !== 1'b0) begin n_fail++; $display("FAIL small_feed_to_done: got done=%b busy=%b want 1/0", bus3.done, bus3.busy); end
    n_checks++; if (bus3.cur_row !== 4'd2 || bus3.cur_col !== 4'd2) begin n_fail++; $display("FAIL small_final_pos: got (%0d,%0d) want (2,2)", bus3.cur_row, bus3.cur_col); end
    $display("3x3 frame: sequence errors=%0d done=%b", bad, bus3.done);
  endtask

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0;
    bus3.start = 1'b0; bus3.pause = 1'b0;
    test_reset();
    test_idle_ignore();
    test_basic();
    test_busy_start();
    test_pause();
    test_timeout();
    test_reset_mid();
    test_small_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before 2ms");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/depthwise_layer_sequencer.md
DEPTHWISE_LAYER_SEQUENCER -- requirements
Module: depthwise_layer_sequencer

Interface
REQ-001 SHALL have parameter IMG_WIDHT, default 44, frame width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT, default 44, frame height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 12, buffer address width; must satisfy 2^ADDR_W >= IMG_WIDHT*IMG_HEIGHT.
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 4096, maximum idle cycles allowed in DRAIN between conv_valid_out pulses.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 start  in  1  one-cycle pulse; begins one frame.
REQ-008 pause  in  1  upstream hold; while 1, no new source read is issued.
REQ-009 src_rd_en  out  1  source-buffer read strobe; the buffer has 1-cycle synchronous read latency.
REQ-010 src_rd_addr  out  ADDR_W  source read address, raster order.
REQ-011 conv_valid_in  out  1  drives Valid_In of the 16-channel depthwise datapath.
REQ-012 conv_valid_out  in  1  AND of all channel Valid_Out signals from the datapath.
REQ-013 dst_wr_en  out  1  destination-buffer write strobe.
REQ-014 dst_wr_addr  out  ADDR_W  destination write address.
REQ-015 cur_row, cur_col  out  ADDR_W each  row and column of the pixel most recently read.
REQ-016 busy  out  1  high in FEED and DRAIN.
REQ-017 done  out  1  one-cycle pulse when a frame completes.
REQ-018 err_timeout  out  1  sticky error flag, cleared by start or rst.

Function
REQ-019 Let N = IMG_WIDHT*IMG_HEIGHT.
REQ-020 State machine SHALL have states IDLE, FEED, DRAIN, DONE, ERR.
- IDLE->FEED on start.
- FEED->DRAIN after read N-1 is issued.
- DRAIN->DONE when output N-1 is written.
- DRAIN->ERR when the timeout counter reaches DRAIN_TIMEOUT.
- DONE->IDLE after 1 cycle.
- ERR->FEED on start.
REQ-021 In FEED, src_rd_en SHALL equal !pause, with src_rd_addr = rd_cnt; rd_cnt increments on each issued read.
REQ-022 conv_valid_in SHALL be src_rd_en delayed by exactly one cycle, so it aligns with the buffer read data.
REQ-023 cur_col SHALL increment on each read and wrap from IMG_WIDHT-1 to 0; cur_row SHALL increment on each wrap.
REQ-024 dst_wr_en SHALL equal conv_valid_out while in FEED or DRAIN, with dst_wr_addr = wr_cnt; wr_cnt increments per write.
REQ-025 conv_valid_out in IDLE, DONE or ERR SHALL be ignored, with no write issued.
REQ-026 Outputs may arrive during FEED, and SHALL be counted there.
- If output N-1 arrives in the same cycle as the last read is issued, the FSM goes directly FEED->DONE.
REQ-027 The DRAIN timeout counter SHALL clear on entry to DRAIN and on every conv_valid_out, and increment otherwise.
REQ-028 start received while busy SHALL be ignored.
- start received in DONE SHALL be ignored.
- start received in ERR SHALL clear err_timeout and all counters.
REQ-029 done SHALL be high only in DONE.
REQ-030 The end-to-end latency from start to the first src_rd_en SHALL be 1 cycle (registered FSM).

Reset
REQ-031 Asserting rst (0) SHALL asynchronously force:
- state to IDLE;
- all counters to 0;
- src_rd_en, conv_valid_in, dst_wr_en, busy, done and err_timeout to 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame, with no pending conv_valid_in emitted after release.
REQ-033 Reset release SHALL be synchronised externally; the block requires no cycles after release before accepting start.

Structure
REQ-034 The shared package SHALL hold the state encoding (enum IDLE/FEED/DRAIN/DONE/ERR) and the default constants IMG_WIDHT, IMG_HEIGHT and DRAIN_TIMEOUT.
REQ-035 The row/column counter SHALL be one sub-module, raster_pos_counter, with inputs en and clr and outputs row and col.
REQ-036 The FSM, the read/write counters and the timeout counter SHALL reside in the top module; the datapath is instantiated outside this block.

Verification
REQ-037 start with pause=0 and a model datapath of fixed 50-cycle latency -> 1936 reads at addresses 0..1935, 1936 writes at addresses 0..1935, and done 1 cycle after the last write.
REQ-038 pause toggling every 3 cycles during FEED -> no read while pause=1, rd_cnt gaps, and conv_valid_in equal to src_rd_en delayed by 1.
REQ-039 Model withholding the last 5 outputs with DRAIN_TIMEOUT=16 -> ERR after 16 idle cycles and err_timeout=1; a subsequent start clears it and re-runs the frame.
REQ-040 rst pulled low at read 700 -> all outputs 0 immediately; after release and start, reading begins again at address 0.
REQ-041 start pulsed while busy, and conv_valid_out pulsed in IDLE -> no state change and no dst_wr_en.
REQ-042 3x3 frame (IMG_WIDHT=IMG_HEIGHT=3) with zero-latency loopback -> FEED->DONE directly, and cur_row/cur_col sequence (0,0)..(2,2).
